// File: rtl/cim_reg_pkg.sv
// cim_reg_pkg: shared FSM state type and register-map constants for the
// CIM register-write arbiter (cim_reg_arbiter and cim_rr_arbiter).
package cim_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LOCK  = 2'd2
    } arb_state_t;

    // Controller register map
    localparam int unsigned ADDR_EN_COL = 4;
    localparam int unsigned ADDR_ADD0   = 5;
    localparam int unsigned ADDR_ADD1   = 6;
    localparam int unsigned ADDR_CONF0  = 7;
    localparam int unsigned ADDR_CONF1  = 8;
    localparam int unsigned ADDR_CONF2  = 9;
    localparam int unsigned ADDR_CONF3  = 10;

    // Only this window is forwarded to the controller
    localparam int unsigned ADDR_MIN = ADDR_EN_COL;
    localparam int unsigned ADDR_MAX = ADDR_CONF3;

    function automatic logic addr_legal(input logic [31:0] addr);
        return (addr >= ADDR_MIN) && (addr <= ADDR_MAX);
    endfunction

endpackage

// File: rtl/cim_rr_arbiter.sv
// cim_rr_arbiter: combinational 2-way round-robin pick between host and
// sequencer. i_ptr_seq=0 favours the host, 1 favours the sequencer.
module cim_rr_arbiter
    import cim_reg_pkg::*;
(
    input  logic       i_req_host,
    input  logic       i_req_seq,
    input  logic       i_ptr_seq,
    output logic [1:0] o_grant
);

    // Favourite wins when requesting, otherwise the other requester
    always_comb begin
        o_grant = '0;
        if (i_ptr_seq) begin
            if (i_req_seq)       o_grant = 2'b10;
            else if (i_req_host) o_grant = 2'b01;
        end else begin
            if (i_req_host)      o_grant = 2'b01;
            else if (i_req_seq)  o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/cim_reg_arbiter.sv
// cim_reg_arbiter: schedules host and sequencer writes onto the CIM
// controller register bus (reg_en/a_reg/d_reg) with round-robin, optional
// burst lock (bounded by MAX_LOCK) and address filtering.
// Optional feature: define CIM_ARB_DEFER_EN to hold off new grants while
// cim_busy is high.
module cim_reg_arbiter
    import cim_reg_pkg::*;
#(
    parameter int unsigned REG_ADDR       = 4,
    parameter int unsigned REG_DATA_WIDTH = 32,
    parameter int unsigned MAX_LOCK       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      host_valid,
    input  logic [REG_ADDR-1:0]       host_addr,
    input  logic [REG_DATA_WIDTH-1:0] host_data,
    input  logic                      host_lock,
    output logic                      host_ready,
    input  logic                      seq_valid,
    input  logic [REG_ADDR-1:0]       seq_addr,
    input  logic [REG_DATA_WIDTH-1:0] seq_data,
    input  logic                      seq_lock,
    output logic                      seq_ready,
    input  logic                      cim_busy,
    output logic                      reg_en,
    output logic [REG_ADDR-1:0]       a_reg,
    output logic [REG_DATA_WIDTH-1:0] d_reg,
    output logic [1:0]                grant,
    output logic                      err_addr
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_t                r_state;
    arb_state_t                w_next_state;
    logic [1:0]                r_owner;
    logic                      r_lock_cap;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_ptr_seq;
    logic                      r_reg_en;
    logic [REG_ADDR-1:0]       r_a_reg;
    logic [REG_DATA_WIDTH-1:0] r_d_reg;
    logic                      r_err;

    logic                      w_defer;
    logic                      w_req_host;
    logic                      w_req_seq;
    logic [1:0]                w_pick;
    logic                      w_host_ready;
    logic                      w_seq_ready;
    logic [1:0]                w_grant;
    logic                      w_xfer_host;
    logic                      w_xfer_seq;
    logic                      w_xfer;
    logic [REG_ADDR-1:0]       w_sel_addr;
    logic [REG_DATA_WIDTH-1:0] w_sel_data;
    logic                      w_sel_lock;
    logic                      w_legal;
    logic                      w_own_lock;
    logic [CNT_W-1:0]          w_cnt_inc;
    logic                      w_stay_locked;
    logic                      w_release;

`ifdef CIM_ARB_DEFER_EN
    assign w_defer = cim_busy;
`else
    logic w_unused_busy;
    assign w_unused_busy = cim_busy;
    assign w_defer       = 1'b0;
`endif

    assign w_req_host = host_valid & ~w_defer;
    assign w_req_seq  = seq_valid  & ~w_defer;

    cim_rr_arbiter u_rr (
        .i_req_host (w_req_host),
        .i_req_seq  (w_req_seq),
        .i_ptr_seq  (r_ptr_seq),
        .o_grant    (w_pick)
    );

    assign w_xfer_host = host_valid & w_host_ready;
    assign w_xfer_seq  = seq_valid  & w_seq_ready;
    assign w_xfer      = w_xfer_host | w_xfer_seq;
    assign w_sel_addr  = w_xfer_seq ? seq_addr : host_addr;
    assign w_sel_data  = w_xfer_seq ? seq_data : host_data;
    assign w_sel_lock  = w_xfer_seq ? seq_lock : host_lock;
    assign w_legal     = addr_legal(32'(w_sel_addr));
    assign w_own_lock  = r_owner[1] ? seq_lock : host_lock;

    // The issue being retired counts toward the burst; keep the bus only if
    // that count is still below the bound.
    assign w_cnt_inc     = r_cnt + CNT_W'(1);
    assign w_stay_locked = r_lock_cap && (32'(w_cnt_inc) < MAX_LOCK);
    assign w_release     = ((r_state == ISSUE) && !w_stay_locked) ||
                           ((r_state == LOCK) && !w_xfer && !w_own_lock);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_xfer) w_next_state = ISSUE;
            ISSUE:   w_next_state = w_stay_locked ? LOCK : IDLE;
            LOCK: begin
                if (w_xfer)         w_next_state = ISSUE;
                else if (w_release) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Ready and grant decode; nothing is accepted while reset is asserted
    always_comb begin
        w_host_ready = 1'b0;
        w_seq_ready  = 1'b0;
        w_grant      = '0;
        case (r_state)
            IDLE: begin
                w_host_ready = w_pick[0];
                w_seq_ready  = w_pick[1];
            end
            ISSUE: w_grant = r_owner;
            LOCK: begin
                w_host_ready = r_owner[0] & w_req_host;
                w_seq_ready  = r_owner[1] & w_req_seq;
                w_grant      = r_owner;
            end
            default: ;
        endcase
        if (!rst) begin
            w_host_ready = 1'b0;
            w_seq_ready  = 1'b0;
        end
    end

    // Ownership, burst counter and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner    <= '0;
            r_lock_cap <= 1'b0;
            r_cnt      <= '0;
            r_ptr_seq  <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_owner    <= {w_xfer_seq, w_xfer_host};
                r_lock_cap <= w_sel_lock;
            end else if (w_release) begin
                r_owner   <= '0;
                r_ptr_seq <= r_owner[0];
            end
            if (r_state == ISSUE)  r_cnt <= w_stay_locked ? w_cnt_inc : '0;
            else if (w_release)    r_cnt <= '0;
        end
    end

    // Registered write bus: one-cycle strobe or error pulse per accepted write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_en <= 1'b0;
            r_err    <= 1'b0;
            r_a_reg  <= '0;
            r_d_reg  <= '0;
        end else begin
            r_reg_en <= w_xfer & w_legal;
            r_err    <= w_xfer & ~w_legal;
            if (w_xfer && w_legal) begin
                r_a_reg <= w_sel_addr;
                r_d_reg <= w_sel_data;
            end
        end
    end

    assign host_ready = w_host_ready;
    assign seq_ready  = w_seq_ready;
    assign grant      = w_grant;
    assign reg_en     = r_reg_en;
    assign a_reg      = r_a_reg;
    assign d_reg      = r_d_reg;
    assign err_addr   = r_err;

endmodule

// File: tb/tb_cim_reg_arbiter.sv
// tb_cim_reg_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level ownership model of the arbiter.
module tb_cim_reg_arbiter;

    localparam int unsigned RA = 4;
    localparam int unsigned RD = 32;
    localparam int unsigned ML = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_valid, host_lock, host_ready;
    logic [RA-1:0] host_addr;
    logic [RD-1:0] host_data;
    logic          seq_valid, seq_lock, seq_ready;
    logic [RA-1:0] seq_addr;
    logic [RD-1:0] seq_data;
    logic          cim_busy;
    logic          reg_en, err_addr;
    logic [RA-1:0] a_reg;
    logic [RD-1:0] d_reg;
    logic [1:0]    grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cim_reg_arbiter #(.REG_ADDR(RA), .REG_DATA_WIDTH(RD), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data),
        .host_lock(host_lock), .host_ready(host_ready),
        .seq_valid(seq_valid), .seq_addr(seq_addr), .seq_data(seq_data),
        .seq_lock(seq_lock), .seq_ready(seq_ready),
        .cim_busy(cim_busy),
        .reg_en(reg_en), .a_reg(a_reg), .d_reg(d_reg),
        .grant(grant), .err_addr(err_addr)
    );

    task automatic drive_quiet();
        host_valid = 0; host_lock = 0; host_addr = '0; host_data = '0;
        seq_valid  = 0; seq_lock  = 0; seq_addr  = '0; seq_data  = '0;
        cim_busy   = 0;
    endtask

    task automatic apply_reset();
        rst = 0;
        drive_quiet();
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 0;
        host_valid = 1; seq_valid = 1;
        #1;
        total++; if (reg_en !== 1'b0)     begin bad++; $display("FAIL rst_reg_en got=%b exp=0", reg_en); end
        total++; if (a_reg !== '0)        begin bad++; $display("FAIL rst_a_reg got=%0h exp=0", a_reg); end
        total++; if (d_reg !== '0)        begin bad++; $display("FAIL rst_d_reg got=%0h exp=0", d_reg); end
        total++; if (grant !== 2'b00)     begin bad++; $display("FAIL rst_grant got=%b exp=00", grant); end
        total++; if (err_addr !== 1'b0)   begin bad++; $display("FAIL rst_err got=%b exp=0", err_addr); end
        total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL rst_host_ready got=%b exp=0", host_ready); end
        total++; if (seq_ready !== 1'b0)  begin bad++; $display("FAIL rst_seq_ready got=%b exp=0", seq_ready); end
        drive_quiet();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_single();
        @(negedge clk);
        host_valid = 1; host_addr = 4'd7; host_data = 32'h8000_0001; host_lock = 0;
        #1;
        total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", host_ready); end
        total++; if (reg_en !== 1'b0)     begin bad++; $display("FAIL single_en_pre got=%b exp=0", reg_en); end
        @(negedge clk);
        #1;
        total++; if (reg_en !== 1'b1)          begin bad++; $display("FAIL single_en got=%b exp=1", reg_en); end
        total++; if (a_reg !== 4'd7)           begin bad++; $display("FAIL single_a_reg got=%0h exp=7", a_reg); end
        total++; if (d_reg !== 32'h8000_0001)  begin bad++; $display("FAIL single_d_reg got=%0h exp=80000001", d_reg); end
        total++; if (grant !== 2'b01)          begin bad++; $display("FAIL single_grant got=%b exp=01", grant); end
        total++; if (host_ready !== 1'b0)      begin bad++; $display("FAIL single_ready_issue got=%b exp=0", host_ready); end
        host_valid = 0;
        @(negedge clk);
        #1;
        total++; if (reg_en !== 1'b0)  begin bad++; $display("FAIL single_en_post got=%b exp=0", reg_en); end
        total++; if (grant !== 2'b00)  begin bad++; $display("FAIL single_grant_post got=%b exp=00", grant); end
        total++; if (a_reg !== 4'd7)   begin bad++; $display("FAIL single_a_hold got=%0h exp=7", a_reg); end
    endtask

    task automatic test_both();
        apply_reset();
        host_valid = 1; host_addr = 4'd5; host_data = 32'h1111_0005;
        seq_valid  = 1; seq_addr  = 4'd6; seq_data  = 32'h2222_0006;
        #1;
        total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL both_host_first got=%b exp=1", host_ready); end
        total++; if (seq_ready !== 1'b0)  begin bad++; $display("FAIL both_seq_held got=%b exp=0", seq_ready); end
        @(negedge clk);
        host_valid = 0;
        #1;
        total++; if (reg_en !== 1'b1 || a_reg !== 4'd5) begin bad++; $display("FAIL both_first_write got en=%b a=%0h exp en=1 a=5", reg_en, a_reg); end
        total++; if (seq_ready !== 1'b0) begin bad++; $display("FAIL both_seq_issue got=%b exp=0", seq_ready); end
        @(negedge clk);
        #1;
        total++; if (reg_en !== 1'b0)    begin bad++; $display("FAIL both_gap got=%b exp=0", reg_en); end
        total++; if (seq_ready !== 1'b1) begin bad++; $display("FAIL both_seq_turn got=%b exp=1", seq_ready); end
        @(negedge clk);
        seq_valid = 0;
        #1;
        total++; if (reg_en !== 1'b1 || a_reg !== 4'd6 || d_reg !== 32'h2222_0006)
            begin bad++; $display("FAIL both_second_write got en=%b a=%0h d=%0h exp en=1 a=6 d=22220006", reg_en, a_reg, d_reg); end
        @(negedge clk);
    endtask

    task automatic test_lock();
        logic [RD-1:0] obs[$];
        logic [RD-1:0] exp_d;
        bit pxh, pxs, hdone;
        int sidx, hr_cnt;
        sidx = 0; hdone = 0; hr_cnt = 0; pxh = 0; pxs = 0;
        @(negedge clk);
        seq_valid = 1; seq_lock = 1; seq_addr = 4'd4; seq_data = 32'h5000_0000;
        host_valid = 0; host_lock = 0; host_addr = 4'd9; host_data = 32'hA5A5_0009;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (reg_en === 1'b1) obs.push_back(d_reg);
            if (host_ready === 1'b1) hr_cnt++;
            pxh = host_valid & host_ready;
            pxs = seq_valid & seq_ready;
            @(negedge clk);
            if (pxs) begin
                sidx++;
                if (sidx == 1) host_valid = 1;
                if (sidx < 12) begin
                    seq_addr = 4'(4 + (sidx % 7));
                    seq_data = 32'h5000_0000 + 32'(sidx);
                end else begin
                    seq_valid = 0;
                end
            end
            if (pxh) begin host_valid = 0; hdone = 1; end
        end
        seq_lock = 0;
        repeat (2) @(negedge clk);
        total++; if (hr_cnt != 1) begin bad++; $display("FAIL lock_host_ready_cycles got=%0d exp=1", hr_cnt); end
        total++;
        if (obs.size() != 13) begin
            bad++; $display("FAIL lock_write_count got=%0d exp=13", obs.size());
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (i < 8)       exp_d = 32'h5000_0000 + 32'(i);
                else if (i == 8) exp_d = 32'hA5A5_0009;
                else             exp_d = 32'h5000_0000 + 32'(i - 1);
                total++;
                if (obs[i] !== exp_d) begin bad++; $display("FAIL lock_order[%0d] got=%0h exp=%0h", i, obs[i], exp_d); end
            end
        end
    endtask

    task automatic test_illegal();
        int hidx, err_cnt, en_cnt;
        bit pxh;
        hidx = 0; err_cnt = 0; en_cnt = 0; pxh = 0;
        @(negedge clk);
        host_valid = 1; host_lock = 0; host_addr = 4'd2; host_data = 32'hDEAD_0002;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (err_addr === 1'b1) err_cnt++;
            if (reg_en === 1'b1) en_cnt++;
            pxh = host_valid & host_ready;
            @(negedge clk);
            if (pxh) begin
                hidx++;
                if (hidx == 1) begin host_addr = 4'd12; host_data = 32'hDEAD_000C; end
                else host_valid = 0;
            end
        end
        total++; if (hidx != 2)    begin bad++; $display("FAIL illegal_accepted got=%0d exp=2", hidx); end
        total++; if (err_cnt != 2) begin bad++; $display("FAIL illegal_err_pulses got=%0d exp=2", err_cnt); end
        total++; if (en_cnt != 0)  begin bad++; $display("FAIL illegal_reg_en got=%0d exp=0", en_cnt); end
        total++; if (a_reg !== 4'd8 || d_reg !== 32'h5000_000B)
            begin bad++; $display("FAIL illegal_bus_hold got a=%0h d=%0h exp a=8 d=5000000b", a_reg, d_reg); end
    endtask

    task automatic test_busy();
        int first, en_cnt, exp_first;
`ifdef CIM_ARB_DEFER_EN
        exp_first = 5;
`else
        exp_first = 0;
`endif
        first = -1; en_cnt = 0;
        @(negedge clk);
        cim_busy = 1; host_valid = 1; host_lock = 0; host_addr = 4'd5; host_data = 32'hB05E_0005;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (reg_en === 1'b1) en_cnt++;
            if (host_ready === 1'b1 && first < 0) first = c;
            @(negedge clk);
            if (c == 4) cim_busy = 0;
            if (first >= 0) host_valid = 0;
        end
        total++; if (first != exp_first) begin bad++; $display("FAIL busy_first_ready got=%0d exp=%0d", first, exp_first); end
        total++; if (en_cnt != 1)        begin bad++; $display("FAIL busy_writes got=%0d exp=1", en_cnt); end
        cim_busy = 0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        host_valid = 1; host_lock = 1; host_addr = 4'd10; host_data = 32'hC0DE_000A;
        @(negedge clk);
        host_valid = 0;
        #1;
        total++; if (reg_en !== 1'b1) begin bad++; $display("FAIL mid_issue_en got=%b exp=1", reg_en); end
        #1;
        rst = 0;
        #1;
        total++; if (reg_en !== 1'b0)  begin bad++; $display("FAIL mid_rst_en got=%b exp=0", reg_en); end
        total++; if (grant !== 2'b00)  begin bad++; $display("FAIL mid_rst_grant got=%b exp=00", grant); end
        @(negedge clk);
        rst = 1;
        host_lock = 0;
        host_valid = 1; host_addr = 4'd4; host_data = 32'h1;
        seq_valid  = 1; seq_addr  = 4'd5; seq_data  = 32'h2;
        #1;
        total++; if (host_ready !== 1'b1 || seq_ready !== 1'b0)
            begin bad++; $display("FAIL mid_rr_host got h=%b s=%b exp h=1 s=0", host_ready, seq_ready); end
        @(negedge clk);
        drive_quiet();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        bit m_iss, m_cap_lock, m_fav_host, dfr, e_hr, e_sr, xh, xs, sl;
        int m_own, m_burst;
        logic e_en, e_err;
        logic [1:0] e_grant;
        logic [RA-1:0] m_a, sa;
        logic [RD-1:0] m_d, sd;
        apply_reset();
        m_iss = 0; m_cap_lock = 0; m_fav_host = 1; m_own = 0; m_burst = 0;
        e_en = 0; e_err = 0; e_grant = 2'b00; m_a = '0; m_d = '0; xh = 0; xs = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            total++; if (reg_en !== e_en)    begin bad++; $display("FAIL rnd_reg_en c=%0d got=%b exp=%b", c, reg_en, e_en); end
            total++; if (err_addr !== e_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err_addr, e_err); end
            total++; if (grant !== e_grant)  begin bad++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, grant, e_grant); end
            total++; if (a_reg !== m_a || d_reg !== m_d)
                begin bad++; $display("FAIL rnd_bus c=%0d got a=%0h d=%0h exp a=%0h d=%0h", c, a_reg, d_reg, m_a, m_d); end
            if (xh) host_valid = 0;
            if (xs) seq_valid = 0;
            if (!host_valid) begin
                host_lock = 1'($urandom % 2);
                if ($urandom % 3 == 0) begin host_valid = 1; host_addr = 4'($urandom % 16); host_data = $urandom; end
            end
            if (!seq_valid) begin
                seq_lock = 1'($urandom % 2);
                if ($urandom % 3 == 0) begin seq_valid = 1; seq_addr = 4'($urandom % 16); seq_data = $urandom; end
            end
            cim_busy = ($urandom % 4 == 0);
            #1;
`ifdef CIM_ARB_DEFER_EN
            dfr = cim_busy;
`else
            dfr = 1'b0;
`endif
            // Who may be accepted this cycle: nobody while a write is going out,
            // only the holder while the bus is held, else the favourite first.
            e_hr = 0; e_sr = 0;
            if (!m_iss && !dfr) begin
                if (m_own == 1)      e_hr = host_valid;
                else if (m_own == 2) e_sr = seq_valid;
                else if (m_fav_host) begin
                    if (host_valid) e_hr = 1; else if (seq_valid) e_sr = 1;
                end else begin
                    if (seq_valid) e_sr = 1; else if (host_valid) e_hr = 1;
                end
            end
            total++; if (host_ready !== e_hr) begin bad++; $display("FAIL rnd_host_ready c=%0d got=%b exp=%b", c, host_ready, e_hr); end
            total++; if (seq_ready !== e_sr)  begin bad++; $display("FAIL rnd_seq_ready c=%0d got=%b exp=%b", c, seq_ready, e_sr); end
            xh = host_valid & e_hr;
            xs = seq_valid & e_sr;
            e_en = 0; e_err = 0;
            if (xh || xs) begin
                sa = xh ? host_addr : seq_addr;
                sd = xh ? host_data : seq_data;
                sl = xh ? host_lock : seq_lock;
                if (sa >= 4 && sa <= 10) begin e_en = 1; m_a = sa; m_d = sd; end
                else e_err = 1;
            end
            if (m_iss) begin
                m_iss = 0;
                m_burst++;
                if (!(m_cap_lock && m_burst < ML)) begin
                    m_fav_host = (m_own == 2); m_own = 0; m_burst = 0;
                end
            end else if (xh || xs) begin
                m_own = xh ? 1 : 2; m_cap_lock = sl; m_iss = 1;
            end else if (m_own != 0) begin
                if (!((m_own == 1) ? host_lock : seq_lock)) begin
                    m_fav_host = (m_own == 2); m_own = 0; m_burst = 0;
                end
            end
            e_grant = (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00;
        end
        drive_quiet();
    endtask

    initial begin
        rst = 0;
        drive_quiet();
        test_reset();
        test_single();
        test_both();
        test_lock();
        test_illegal();
        test_busy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cim_reg_arbiter.md
# cim_reg_arbiter

Two-requester scheduler for the CIM controller's register-write bus (`reg_en` / `a_reg` / `d_reg`).
- **Requesters:** the host-side configuration port and the autonomous sequencer port, each with a valid/ready handshake.
- **Function:** round-robin arbitration, optional bus lock for bursts, and address filtering. Each accepted write is issued as one registered single-cycle pulse.
- **Placement:** sits directly upstream of the CIM controller, so the controller's stall window is exactly one cycle per write.

## Interface
Parameters:
- `REG_ADDR`, 4: address width of the register bus.
- `REG_DATA_WIDTH`, 32: data width of the register bus.
- `MAX_LOCK`, 8: maximum consecutive writes one owner may issue under lock before forced release (≥1).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: asynchronous, active-low.
- `host_valid`  in  1  host write request.
- `host_addr`  in  REG_ADDR  host write address.
- `host_data`  in  REG_DATA_WIDTH  host write data.
- `host_lock`  in  1  host wants to keep ownership after its current write.
- `host_ready`  out  1  host write accepted this cycle (valid & ready = transfer).
- `seq_valid`, `seq_addr`, `seq_data`, `seq_lock`, `seq_ready`: same as the host set, for the sequencer.
- `cim_busy`  in  1  controller is in CAL (driven from `cal_b`).
- `reg_en`  out  1  write strobe to the controller (registered).
- `a_reg`  out  REG_ADDR  write address (registered).
- `d_reg`  out  REG_DATA_WIDTH  write data (registered).
- `grant`  out  2  current owner, one-hot: bit0 = host, bit1 = seq; 0 when no owner.
- `err_addr`  out  1  one-cycle pulse when an accepted write had an illegal address.

## Operation
- **States:** IDLE, ISSUE, LOCK.
- **IDLE:**
  - If any valid is present (and not deferred), pick the owner by round-robin. The round-robin pointer is host-first after reset.
  - The owner's ready is asserted combinationally. Capture addr/data and go to ISSUE.
- **ISSUE:**
  - If the captured address is legal (4..10), drive `reg_en`=1 with `a_reg`/`d_reg` for exactly this cycle.
  - Otherwise drive `reg_en`=0 and `err_addr`=1 for this cycle.
  - Increment the lock counter.
  - If the owner's lock=1 and lock counter < `MAX_LOCK`, go to LOCK.
  - Otherwise go to IDLE: clear the counter, point the round-robin at the other requester, set `grant`=0.
- **LOCK:**
  - Only the owner may be granted; its ready is combinational on its valid.
  - Owner valid → capture, go to ISSUE.
  - Owner lock drops with no valid → go to IDLE (pointer → other requester).
  - The other requester's ready is always 0.
- **Outputs outside ISSUE:** `a_reg`/`d_reg` hold their last issued value; `reg_en`=0.
- **Simultaneous valids in IDLE:** only the round-robin favourite is readied; the loser's ready stays 0 and its request is held.
- **Address legality:** 0..3 and 11..15 are dropped, never forwarded.

## Timing
- Transfer at edge N → `reg_en` high for cycle N+1 only. The next transfer is no earlier than N+2, so sustained throughput is one write per 2 cycles.
- Ready is never asserted in ISSUE.
- **Reset values:** `reg_en`=0, `a_reg`=0, `d_reg`=0, `host_ready`=`seq_ready`=0, `grant`=0, `err_addr`=0, state IDLE, lock counter 0, round-robin = host.
- **Reset mid-operation:** asynchronous clear. An in-flight ISSUE is dropped (`reg_en` falls immediately, no partial write). Lock ownership is lost.
- **Lock starvation bound:** after `MAX_LOCK` issues the owner is forced to IDLE even with lock=1. The other requester wins if it is valid.

## Configuration
- **`CIM_ARB_DEFER_EN` defined:** while `cim_busy`=1, no new grant in IDLE and no ready in LOCK. A write already in ISSUE completes. The lock counter does not advance while deferred.
- **`CIM_ARB_DEFER_EN` undefined:** `cim_busy` is ignored and writes are issued regardless of controller state. The controller's own stall absorbs them.

## Structure
- **Package `cim_reg_pkg`:**
  - state enum: IDLE, ISSUE, LOCK;
  - address constants: ADDR_EN_COL=4, ADDR_ADD0=5, ADDR_ADD1=6, ADDR_CONF0..3=7..10;
  - legal range bounds: ADDR_MIN=4, ADDR_MAX=10.
- **Sub-module `cim_rr_arbiter`:** 2-way round-robin pick. Inputs: two requests, pointer. Output: one-hot grant. Combinational, instantiated once.

## Test plan
- Host only, addr 7, data 0x8000_0001, lock=0 → `host_ready` pulse at N; `reg_en`=1, `a_reg`=7, `d_reg`=0x8000_0001 at N+1 only; `grant` back to 0 at N+2.
- Host and seq valid together from reset (host addr 5, seq addr 6) → host issued first, seq issued at the next transfer, order 5 then 6, 2 cycles apart.
- Seq lock=1 with 12 back-to-back writes, host valid throughout, `MAX_LOCK`=8 → 8 seq writes, then 1 host write, then the remaining seq writes; host ready never asserted during the lock.
- Host addr 2 and addr 12 → both accepted; `err_addr` pulses twice; `reg_en` stays 0 on both.
- With `CIM_ARB_DEFER_EN`, `cim_busy`=1 for 5 cycles, host valid → no ready for 5 cycles; transfer on the first cycle after `cim_busy` falls. Without the macro → transfer on the first cycle.
- `rst` asserted during an ISSUE cycle → `reg_en`=0 immediately, `grant`=0; after release, round-robin favours the host.
